// File: rtl/screen_pkg.sv
// Shared types for the screen-clear sequencer: FSM states,
// PIO command bit positions and the RGB565 pixel type.
package screen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_e;

    localparam int CMD_GO        = 0;
    localparam int CMD_ABORT     = 1;
    localparam int CMD_COLOR_LSB = 16;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/screen_clear_ctrl_pixel_addr_gen.sv
// Raster walker: x/y pixel counters, line wrap, byte address of the
// current pixel and a flag marking the last pixel of the frame.
module pixel_addr_gen #(
    parameter int          H_RES     = 320,
    parameter int          V_RES     = 240,
    parameter int          X_BITS    = 9,
    parameter int          Y_BITS    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        step,
    output logic [31:0] address,
    output logic        last
);

    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              x_end;

    assign x_end = (x == X_BITS'(H_RES - 1));
    assign last  = x_end && (y == Y_BITS'(V_RES - 1));

    // Line stride is 2^(X_BITS+1) bytes, pixels are 2 bytes wide
    assign address = BASE_ADDR
                   + (32'(y) << (X_BITS + 1))
                   + (32'(x) << 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x_end) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/screen_clear_ctrl.sv
// Full-frame pixel buffer fill sequencer driven by a PIO command word.
// Optional interrupt output enabled with SCREEN_CLEAR_IRQ_EN.
module screen_clear_ctrl
    import screen_pkg::*;
#(
    parameter int          H_RES     = 320,
    parameter int          V_RES     = 240,
    parameter int          X_BITS    = 9,
    parameter int          Y_BITS    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [15:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
`ifdef SCREEN_CLEAR_IRQ_EN
    output logic        irq,
    input  logic        irq_ack,
`endif
    output logic [15:0] frame_count
);

    state_e  state;
    state_e  state_nxt;
    logic    go_q;
    logic    go_edge;
    logic    abort_q;
    logic    abort;
    logic    start;
    logic    accept;
    logic    last;
    rgb565_t colour;
    logic    unused_cmd;

    assign unused_cmd = ^cmd[CMD_COLOR_LSB-1:CMD_ABORT+1];

    assign go_edge = cmd[CMD_GO] && !go_q;
    assign abort   = cmd[CMD_ABORT] || abort_q;
    assign start   = (state == IDLE) && go_edge && !cmd[CMD_ABORT];
    assign accept  = m_write && !m_waitrequest;

    assign m_write     = (state == WRITE);
    assign busy        = (state == WRITE);
    assign done        = (state == DONE);
    assign m_writedata = colour;

    pixel_addr_gen #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .step    (accept),
        .address (m_address),
        .last    (last)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = WRITE;
            end
            WRITE: begin
                if (accept) begin
                    if (abort)     state_nxt = IDLE;
                    else if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            go_q        <= 1'b0;
            abort_q     <= 1'b0;
            colour      <= '0;
            frame_count <= '0;
        end else begin
            state <= state_nxt;
            go_q  <= cmd[CMD_GO];
            if (start)
                colour <= cmd[31:CMD_COLOR_LSB];
            // Abort seen at any point in the frame sticks until the
            // in-flight write is accepted
            if (state != WRITE)
                abort_q <= 1'b0;
            else if (cmd[CMD_ABORT])
                abort_q <= 1'b1;
            if (state == DONE)
                frame_count <= frame_count + 16'd1;
        end
    end

`ifdef SCREEN_CLEAR_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else if (irq_ack)
            irq <= 1'b0;
        else if (state == DONE)
            irq <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_screen_clear_ctrl.sv
// Scoreboard bench for screen_clear_ctrl on a 4x2 frame.
// Covers plain fill, stalls, go level hold, abort, reset and irq.
module tb_screen_clear_ctrl;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cmd;
    logic [31:0] m_address;
    logic        m_write;
    logic [15:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
`ifdef SCREEN_CLEAR_IRQ_EN
    logic        irq;
    logic        irq_ack;
`endif

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];
    int acc_cnt   = 0;
    int done_cnt  = 0;
    int stall_cyc = 0;

    logic stall_en = 1'b0;
    logic force_wr = 1'b0;
    int   stalled_idx = -1;
    int   wait_cnt = 0;

    screen_clear_ctrl #(
        .H_RES     (H),
        .V_RES     (V),
        .X_BITS    (9),
        .Y_BITS    (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd           (cmd),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
`ifdef SCREEN_CLEAR_IRQ_EN
        .irq           (irq),
        .irq_ack       (irq_ack),
`endif
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] c);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back({BASE + 32'(y * 1024) + 32'(x * 2), c});
    endtask

    task automatic drive(input logic [31:0] v);
        @(posedge clk);
        #1 cmd = v;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!done && n < 400);
        check(tag, 48'(done), 48'd1);
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        check(tag, 48'(acc_cnt >= target), 48'd1);
    endtask

    // Slave model: optional 3-cycle stall on every odd-indexed write
    initial begin
        m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wait_cnt > 0) begin
                wait_cnt--;
                m_waitrequest = (wait_cnt != 0);
            end else if (stall_en && m_write && acc_cnt[0] &&
                         stalled_idx != acc_cnt) begin
                stalled_idx   = acc_cnt;
                wait_cnt      = 3;
                m_waitrequest = 1'b1;
            end else begin
                m_waitrequest = force_wr;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && done)
            done_cnt++;
        if (reset_n && m_write) begin
            check("write_expected", 48'(exp_q.size() != 0), 48'd1);
            if (exp_q.size() != 0) begin
                if (!m_waitrequest) begin
                    check("write", {m_address, m_writedata},
                          exp_q.pop_front());
                    acc_cnt++;
                end else begin
                    check("stall_hold", {m_address, m_writedata}, exp_q[0]);
                    stall_cyc++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int d0;
        int s0;
        cmd     = '0;
        reset_n = 1'b1;
`ifdef SCREEN_CLEAR_IRQ_EN
        irq_ack = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #10;
        check("rst_m_write", 48'(m_write), 48'd0);
        check("rst_addr", 48'(m_address), 48'(BASE));
        check("rst_data", 48'(m_writedata), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_done", 48'(done), 48'd0);
        check("rst_fc", 48'(frame_count), 48'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Plain frame
        a0 = acc_cnt;
        push_frame(16'hF800);
        drive(32'hF800_0001);
        wait_done("f1_done");
        check("f1_busy_at_done", 48'(busy), 48'd0);
        @(negedge clk);
        #1;
        check("f1_fc", 48'(frame_count), 48'd1);
        check("f1_writes", 48'(acc_cnt - a0), 48'd8);
        check("f1_q_empty", 48'(exp_q.size()), 48'd0);
        check("f1_done_cnt", 48'(done_cnt), 48'd1);

        // Frame with stalls on every second write
        drive(32'h0);
        stall_en = 1'b1;
        a0 = acc_cnt;
        s0 = stall_cyc;
        push_frame(16'h001F);
        drive(32'h001F_0001);
        wait_done("f2_done");
        @(negedge clk);
        #1 stall_en = 1'b0;
        check("f2_fc", 48'(frame_count), 48'd2);
        check("f2_writes", 48'(acc_cnt - a0), 48'd8);
        check("f2_stall_cycles", 48'(stall_cyc - s0), 48'd12);
        check("f2_q_empty", 48'(exp_q.size()), 48'd0);

        // go held high retriggers nothing
        repeat (100) @(posedge clk);
        #1;
        check("hold_done_cnt", 48'(done_cnt), 48'd2);
        check("hold_fc", 48'(frame_count), 48'd2);
        check("hold_busy", 48'(busy), 48'd0);

        // New edge; colour change mid-frame is ignored
        drive(32'h0);
        push_frame(16'h07E0);
        drive(32'h07E0_0001);
        repeat (3) @(posedge clk);
        #1 cmd = 32'h1234_0001;
        wait_done("f3_done");
        @(negedge clk);
        #1;
        check("f3_fc", 48'(frame_count), 48'd3);

        // Abort during stalled write #3
        drive(32'h0);
        a0 = acc_cnt;
        d0 = done_cnt;
        push_frame(16'hAAAA);
        drive(32'hAAAA_0001);
        wait_acc(a0 + 2, "ab_reach");
        force_wr = 1'b1;
        drive(32'hAAAA_0003);
        repeat (3) @(negedge clk);
        #1;
        check("ab_busy_stall", 48'(busy), 48'd1);
        check("ab_write_held", 48'(m_write), 48'd1);
        force_wr = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("ab_busy", 48'(busy), 48'd0);
        check("ab_writes", 48'(acc_cnt - a0), 48'd3);
        check("ab_no_done", 48'(done_cnt - d0), 48'd0);
        check("ab_fc", 48'(frame_count), 48'd3);
        check("ab_q_left", 48'(exp_q.size()), 48'd5);
        exp_q.delete();

        // Abort and go edge together in IDLE: no clear
        drive(32'h0);
        drive(32'h0000_0003);
        repeat (5) @(negedge clk);
        #1;
        check("ab_go_busy", 48'(busy), 48'd0);
        drive(32'h0);

        // Reset while write #5 is presented
        a0 = acc_cnt;
        push_frame(16'h5555);
        drive(32'h5555_0001);
        wait_acc(a0 + 4, "rs_reach");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        cmd     = 32'h0;
        #1;
        check("rs_m_write", 48'(m_write), 48'd0);
        check("rs_busy", 48'(busy), 48'd0);
        check("rs_fc", 48'(frame_count), 48'd0);
        check("rs_addr", 48'(m_address), 48'(BASE));
        check("rs_q_left", 48'(exp_q.size()), 48'd4);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push_frame(16'h0F0F);
        drive(32'h0F0F_0001);
        wait_done("rs2_done");
        @(negedge clk);
        #1;
        check("rs2_fc", 48'(frame_count), 48'd1);
        check("rs2_q_empty", 48'(exp_q.size()), 48'd0);

`ifdef SCREEN_CLEAR_IRQ_EN
        check("irq_set", 48'(irq), 48'd1);
        repeat (5) @(posedge clk);
        #1;
        check("irq_sticky", 48'(irq), 48'd1);
        irq_ack = 1'b1;
        @(posedge clk);
        #1 irq_ack = 1'b0;
        check("irq_ack", 48'(irq), 48'd0);
        drive(32'h0);
        push_frame(16'h1111);
        drive(32'h1111_0001);
        wait_done("irq_f1_done");
        @(negedge clk);
        #1;
        check("irq_f1", 48'(irq), 48'd1);
        drive(32'h0);
        push_frame(16'h2222);
        drive(32'h2222_0001);
        wait_done("irq_f2_done");
        irq_ack = 1'b1;
        @(posedge clk);
        #1 irq_ack = 1'b0;
        check("irq_ack_wins", 48'(irq), 48'd0);
        check("irq_fc", 48'(frame_count), 48'd3);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
